// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU background tile fetcher.
// Optional one-entry tile cache is enabled with PPU_TILE_CACHE_EN.
package ppu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_NT    = 3'd1;
    localparam state_t S_AT    = 3'd2;
    localparam state_t S_PT_LO = 3'd3;
    localparam state_t S_PT_HI = 3'd4;
    localparam state_t S_DONE  = 3'd5;

    localparam logic [1:0] MIR_HORIZ     = 2'd0;
    localparam logic [1:0] MIR_VERT      = 2'd1;
    localparam logic [1:0] MIR_SINGLE_LO = 2'd2;
    localparam logic [1:0] MIR_SINGLE_HI = 2'd3;

    localparam int unsigned AT_OFFSET = 'h3C0;
    localparam int unsigned NT_SIZE   = 'h400;
    localparam int unsigned PT_HALF   = 'h1000;

    localparam logic [9:0] ROW_WRAP = 10'd480;
    localparam logic [9:0] NT_ROWS  = 10'd240;

    typedef struct packed {
        logic [8:0] pix_row;
        logic [8:0] pix_col;
        logic [7:0] scroll_x;
        logic [7:0] scroll_y;
        logic       nt_h;
        logic       nt_v;
        logic       pt_sel;
        logic [1:0] mirror;
    } fetch_req_t;

    function automatic logic [1:0] pal_sel(
        input logic [7:0] at_byte,
        input logic [2:0] shift
    );
        logic [7:0] s;
        s = at_byte >> shift;
        return s[1:0];
    endfunction

endpackage

// File: rtl/ppu_scroll_map.sv
// Scroll/mirroring mapping from screen position to NT, AT and PT addresses.
// Purely combinational; used by ppu_tile_fetcher.
module ppu_scroll_map
    import ppu_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int unsigned NT_BASE   = 'h2000,
    parameter int unsigned PT_STRIDE = 16
) (
    input  fetch_req_t        req,
    input  logic [7:0]        nt_byte,
    output logic [ADDR_W-1:0] nt_addr,
    output logic [ADDR_W-1:0] at_addr,
    output logic [ADDR_W-1:0] pt_lo_addr,
    output logic [ADDR_W-1:0] pt_hi_addr,
    output logic [2:0]        fine_y,
    output logic [2:0]        fine_x,
    output logic [2:0]        pal_shift
);

    logic [9:0]        row_sum;
    logic [8:0]        row;
    logic [8:0]        col;
    logic [7:0]        nt_row;
    logic [4:0]        coarse_y;
    logic [4:0]        coarse_x;
    logic              v;
    logic              p;
    logic [ADDR_W-1:0] nt_base;
    logic [ADDR_W-1:0] pt_base;

    always_comb begin
        row_sum = 10'(req.pix_row) + 10'(req.scroll_y)
                + (req.nt_v ? NT_ROWS : 10'd0);
        // Max sum is 734, so one subtraction wraps the 480-row space.
        row = (row_sum >= ROW_WRAP) ? 9'(row_sum - ROW_WRAP)
                                    : row_sum[8:0];
        col = req.pix_col + 9'(req.scroll_x) + {req.nt_h, 8'h00};

        v      = (row >= 9'(NT_ROWS));
        nt_row = 8'(v ? row - 9'(NT_ROWS) : row);

        coarse_y = nt_row[7:3];
        fine_y   = nt_row[2:0];
        coarse_x = col[7:3];
        fine_x   = col[2:0];

        unique case (req.mirror)
            MIR_HORIZ:     p = v;
            MIR_VERT:      p = col[8];
            MIR_SINGLE_LO: p = 1'b0;
            MIR_SINGLE_HI: p = 1'b1;
            default:       p = 1'b0;
        endcase

        nt_base = ADDR_W'(NT_BASE) + (p ? ADDR_W'(NT_SIZE) : '0);
        nt_addr = nt_base + ADDR_W'({coarse_y, coarse_x});
        at_addr = nt_base + ADDR_W'(AT_OFFSET)
                + ADDR_W'({coarse_y[4:2], coarse_x[4:2]});

        pt_base    = req.pt_sel ? ADDR_W'(PT_HALF) : '0;
        pt_lo_addr = pt_base
                   + ADDR_W'(nt_byte) * ADDR_W'(PT_STRIDE)
                   + ADDR_W'(fine_y);
        pt_hi_addr = pt_lo_addr + ADDR_W'(8);

        pal_shift = {coarse_y[1], coarse_x[1], 1'b0};
    end

endmodule

// File: rtl/ppu_tile_fetcher.sv
// Background tile fetcher: NT, AT, PT_LO, PT_HI reads per tile.
// Define PPU_TILE_CACHE_EN to add a one-entry tile cache.
module ppu_tile_fetcher
    import ppu_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int unsigned NT_BASE   = 'h2000,
    parameter int unsigned PT_STRIDE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [8:0]        pix_row,
    input  logic [8:0]        pix_col,
    input  logic [7:0]        scroll_x,
    input  logic [7:0]        scroll_y,
    input  logic [7:0]        ctrl,
    input  logic [1:0]        mirror,
    input  logic              cache_inv,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              tile_valid,
    output logic [7:0]        tile_pt_lo,
    output logic [7:0]        tile_pt_hi,
    output logic [1:0]        tile_pal,
    output logic [2:0]        tile_fine_x
);

    state_t            state;
    fetch_req_t        req_d;
    fetch_req_t        req_q;
    fetch_req_t        map_req;
    logic [7:0]        nt_byte_q;
    logic [7:0]        at_byte_q;
    logic [7:0]        lo_q;
    logic [ADDR_W-1:0] nt_addr;
    logic [ADDR_W-1:0] at_addr;
    logic [ADDR_W-1:0] pt_lo_addr;
    logic [ADDR_W-1:0] pt_hi_addr;
    logic [2:0]        fine_y;
    logic [2:0]        fine_x;
    logic [2:0]        pal_shift;
    logic [1:0]        pal;
    logic              hit;
    logic [7:0]        hit_lo;
    logic [7:0]        hit_hi;
    logic [1:0]        hit_pal;
    logic              unused_ctrl;

    assign unused_ctrl = ^{ctrl[7:5], ctrl[3:2]};

    always_comb begin
        req_d.pix_row  = pix_row;
        req_d.pix_col  = pix_col;
        req_d.scroll_x = scroll_x;
        req_d.scroll_y = scroll_y;
        req_d.nt_h     = ctrl[0];
        req_d.nt_v     = ctrl[1];
        req_d.pt_sel   = ctrl[4];
        req_d.mirror   = mirror;
    end

    // Live inputs drive the map only in IDLE, for the cache lookup.
    assign map_req = (state == S_IDLE) ? req_d : req_q;

    ppu_scroll_map #(
        .ADDR_W    (ADDR_W),
        .NT_BASE   (NT_BASE),
        .PT_STRIDE (PT_STRIDE)
    ) u_map (
        .req        (map_req),
        .nt_byte    (nt_byte_q),
        .nt_addr    (nt_addr),
        .at_addr    (at_addr),
        .pt_lo_addr (pt_lo_addr),
        .pt_hi_addr (pt_hi_addr),
        .fine_y     (fine_y),
        .fine_x     (fine_x),
        .pal_shift  (pal_shift)
    );

    assign pal        = pal_sel(at_byte_q, pal_shift);
    assign busy       = (state != S_IDLE);
    assign tile_valid = (state == S_DONE);
    assign mem_req    = (state == S_NT) || (state == S_AT)
                     || (state == S_PT_LO) || (state == S_PT_HI);

    always_comb begin
        mem_addr = '0;
        case (state)
            S_NT:    mem_addr = nt_addr;
            S_AT:    mem_addr = at_addr;
            S_PT_LO: mem_addr = pt_lo_addr;
            S_PT_HI: mem_addr = pt_hi_addr;
            default: mem_addr = '0;
        endcase
    end

`ifdef PPU_TILE_CACHE_EN
    logic              c_vld;
    logic [ADDR_W-1:0] c_nt;
    logic [2:0]        c_fy;
    logic              c_pt;
    logic [7:0]        c_lo;
    logic [7:0]        c_hi;
    logic [1:0]        c_pal;
    logic              refill;

    assign refill  = (state == S_PT_HI) && mem_ack;
    assign hit     = c_vld && !cache_inv && (c_nt == nt_addr)
                  && (c_fy == fine_y) && (c_pt == map_req.pt_sel);
    assign hit_lo  = c_lo;
    assign hit_hi  = c_hi;
    assign hit_pal = c_pal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld <= 1'b0;
            c_nt  <= '0;
            c_fy  <= '0;
            c_pt  <= 1'b0;
            c_lo  <= '0;
            c_hi  <= '0;
            c_pal <= '0;
        end else begin
            if (cache_inv)
                c_vld <= 1'b0;
            else if (refill)
                c_vld <= 1'b1;
            if (refill) begin
                c_nt  <= nt_addr;
                c_fy  <= fine_y;
                c_pt  <= req_q.pt_sel;
                c_lo  <= lo_q;
                c_hi  <= mem_rdata;
                c_pal <= pal;
            end
        end
    end
`else
    logic unused_cache;

    assign unused_cache = ^{cache_inv, fine_y};
    assign hit     = 1'b0;
    assign hit_lo  = '0;
    assign hit_hi  = '0;
    assign hit_pal = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            req_q       <= '0;
            nt_byte_q   <= '0;
            at_byte_q   <= '0;
            lo_q        <= '0;
            tile_pt_lo  <= '0;
            tile_pt_hi  <= '0;
            tile_pal    <= '0;
            tile_fine_x <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    req_q <= req_d;
                    if (hit) begin
                        tile_pt_lo  <= hit_lo;
                        tile_pt_hi  <= hit_hi;
                        tile_pal    <= hit_pal;
                        tile_fine_x <= fine_x;
                        state       <= S_DONE;
                    end else begin
                        state <= S_NT;
                    end
                end
                S_NT: if (mem_ack) begin
                    nt_byte_q <= mem_rdata;
                    state     <= S_AT;
                end
                S_AT: if (mem_ack) begin
                    at_byte_q <= mem_rdata;
                    state     <= S_PT_LO;
                end
                S_PT_LO: if (mem_ack) begin
                    lo_q  <= mem_rdata;
                    state <= S_PT_HI;
                end
                S_PT_HI: if (mem_ack) begin
                    tile_pt_lo  <= lo_q;
                    tile_pt_hi  <= mem_rdata;
                    tile_pal    <= pal;
                    tile_fine_x <= fine_x;
                    state       <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_tile_fetcher.sv
// Scoreboard bench for ppu_tile_fetcher with a wait-state memory responder.
// Cache scenarios adapt when PPU_TILE_CACHE_EN is defined.
module tb_ppu_tile_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  pix_row = '0;
    logic [8:0]  pix_col = '0;
    logic [7:0]  scroll_x = '0;
    logic [7:0]  scroll_y = '0;
    logic [7:0]  ctrl = '0;
    logic [1:0]  mirror = '0;
    logic        cache_inv = 1'b0;
    logic        busy;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        tile_valid;
    logic [7:0]  tile_pt_lo;
    logic [7:0]  tile_pt_hi;
    logic [1:0]  tile_pal;
    logic [2:0]  tile_fine_x;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] nt;
        logic [15:0] at;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [7:0]  dlo;
        logic [7:0]  dhi;
        logic [1:0]  pal;
        logic [2:0]  fx;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] acked_q[$];
    logic [7:0]  nt_val = 8'h24;
    logic [7:0]  at_val = 8'h00;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    logic        in_wait = 1'b0;
    logic [15:0] held_addr = '0;

    ppu_tile_fetcher dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pix_row     (pix_row),
        .pix_col     (pix_col),
        .scroll_x    (scroll_x),
        .scroll_y    (scroll_y),
        .ctrl        (ctrl),
        .mirror      (mirror),
        .cache_inv   (cache_inv),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .tile_valid  (tile_valid),
        .tile_pt_lo  (tile_pt_lo),
        .tile_pt_hi  (tile_pt_hi),
        .tile_pal    (tile_pal),
        .tile_fine_x (tile_fine_x)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_model(input logic [15:0] a);
        if (a >= 16'h2000) begin
            if (a[9:0] >= 10'h3C0)
                return at_val;
            return nt_val;
        end
        return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5A;
    endfunction

    function automatic exp_t model(
        input logic [8:0] pr, input logic [8:0] pc,
        input logic [7:0] sx, input logic [7:0] sy,
        input logic [7:0] c, input logic [1:0] mir
    );
        exp_t e;
        int row, col, h, ntr, cy, fy, cx, p, base;
        bit v;
        row  = (int'(pr) + int'(sy) + (c[1] ? 240 : 0)) % 480;
        col  = (int'(pc) + int'(sx) + (c[0] ? 256 : 0)) % 512;
        v    = (row >= 240);
        h    = col / 256;
        ntr  = v ? row - 240 : row;
        cy   = ntr / 8;
        fy   = ntr % 8;
        cx   = (col % 256) / 8;
        case (mir)
            2'd0:    p = v ? 1 : 0;
            2'd1:    p = h;
            2'd2:    p = 0;
            default: p = 1;
        endcase
        base  = 'h2000 + p * 'h400;
        e.nt  = 16'(base + cy * 32 + cx);
        e.at  = 16'(base + 'h3C0 + (cy / 4) * 8 + cx / 4);
        e.lo  = 16'((c[4] ? 'h1000 : 0) + int'(nt_val) * 16 + fy);
        e.hi  = e.lo + 16'd8;
        e.dlo = mem_model(e.lo);
        e.dhi = mem_model(e.hi);
        e.pal = 2'((int'(at_val) >> (((cy % 4) / 2) * 4
                                   + ((cx % 4) / 2) * 2)) & 3);
        e.fx  = 3'(col % 8);
        return e;
    endfunction

    // Memory slave: acks after ack_delay wait cycles, logs acked addresses.
    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
            in_wait  = 1'b0;
        end else begin
            req_cycles++;
            if (in_wait) begin
                checks++;
                if (mem_addr !== held_addr) begin
                    errors++;
                    $display("FAIL addr_stable: mem_addr=%h required %h",
                             mem_addr, held_addr);
                end
            end else begin
                held_addr = mem_addr;
            end
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model(mem_addr);
                acked_q.push_back(mem_addr);
                wait_cnt  = 0;
                in_wait   = 1'b0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt++;
                in_wait  = 1'b1;
            end
        end
    end

    task automatic inv_cache();
        @(negedge clk);
        cache_inv = 1'b1;
        @(negedge clk);
        cache_inv = 1'b0;
    endtask

    task automatic run_tile(
        input string name,
        input logic [8:0] pr, input logic [8:0] pc,
        input logic [7:0] sx, input logic [7:0] sy,
        input logic [7:0] c, input logic [1:0] mir,
        input logic [7:0] ntv, input logic [7:0] atv,
        input int d, input bit toggle, input bit hit, input bit hold
    );
        exp_t e;
        int nf, exp_lat, cyc;
        bit seen, busy1;
        logic [15:0] a;
`ifdef PPU_TILE_CACHE_EN
        nf = hit ? 0 : 4;
`else
        nf = 4;
`endif
        if (!hit)
            inv_cache();
        ack_delay = d;
        nt_val    = ntv;
        at_val    = atv;
        @(negedge clk);
        pix_row  = pr;
        pix_col  = pc;
        scroll_x = sx;
        scroll_y = sy;
        ctrl     = c;
        mirror   = mir;
        exp_q.push_back(model(pr, pc, sx, sy, c, mir));
        acked_q.delete();
        req_cycles = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold)
            start = 1'b0;
        if (toggle) begin
            pix_row  = 9'($urandom_range(0, 239));
            pix_col  = 9'($urandom_range(0, 255));
            scroll_x = 8'($urandom);
            scroll_y = 8'($urandom);
            ctrl     = 8'($urandom);
            mirror   = 2'($urandom);
        end
        cyc   = 0;
        seen  = 1'b0;
        busy1 = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1)
                busy1 = busy;
            if (tile_valid)
                seen = 1'b1;
        end
        e = exp_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no tile_valid in 200 cycles", name);
            start = 1'b0;
            return;
        end
        exp_lat = (nf == 0) ? 1 : 4 * (d + 1) + 1;
        if (cyc !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d",
                     name, cyc, exp_lat);
        end
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: got %b required 1", name, busy1);
        end
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s mem_req_done: got %b required 0", name, mem_req);
        end
        checks++;
        if (acked_q.size() != nf || req_cycles != nf * (d + 1)) begin
            errors++;
            $display("FAIL %s fetches: got %0d/%0d required %0d/%0d", name,
                     acked_q.size(), req_cycles, nf, nf * (d + 1));
        end else if (nf == 4) begin
            a = acked_q.pop_front();
            checks++;
            if (a !== e.nt) begin
                errors++;
                $display("FAIL %s nt_addr: got %h required %h", name, a, e.nt);
            end
            a = acked_q.pop_front();
            checks++;
            if (a !== e.at) begin
                errors++;
                $display("FAIL %s at_addr: got %h required %h", name, a, e.at);
            end
            a = acked_q.pop_front();
            checks++;
            if (a !== e.lo) begin
                errors++;
                $display("FAIL %s ptlo_addr: got %h required %h", name, a, e.lo);
            end
            a = acked_q.pop_front();
            checks++;
            if (a !== e.hi) begin
                errors++;
                $display("FAIL %s pthi_addr: got %h required %h", name, a, e.hi);
            end
        end
        checks++;
        if ({tile_pt_lo, tile_pt_hi, tile_pal, tile_fine_x}
                !== {e.dlo, e.dhi, e.pal, e.fx}) begin
            errors++;
            $display("FAIL %s tile: got lo=%h hi=%h pal=%0d fx=%0d required lo=%h hi=%h pal=%0d fx=%0d",
                     name, tile_pt_lo, tile_pt_hi, tile_pal, tile_fine_x,
                     e.dlo, e.dhi, e.pal, e.fx);
        end
        if (hold) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (tile_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got valid=%b busy=%b req=%b required 0/0/0",
                     name, tile_valid, busy, mem_req);
        end
        checks++;
        if ({tile_pt_lo, tile_pt_hi, tile_pal, tile_fine_x}
                !== {e.dlo, e.dhi, e.pal, e.fx}) begin
            errors++;
            $display("FAIL %s hold: got lo=%h hi=%h required lo=%h hi=%h",
                     name, tile_pt_lo, tile_pt_hi, e.dlo, e.dhi);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({tile_valid, busy, mem_req, mem_addr, tile_pt_lo, tile_pt_hi,
             tile_pal, tile_fine_x} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b b=%b r=%b a=%h lo=%h hi=%h pal=%0d fx=%0d required all 0",
                     tile_valid, busy, mem_req, mem_addr, tile_pt_lo,
                     tile_pt_hi, tile_pal, tile_fine_x);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_tile("basic", 9'd0, 9'd0, 8'd0, 8'd0, 8'h00, 2'd1,
                 8'h24, 8'h1B, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_scroll();
        run_tile("scroll_x", 9'd10, 9'd20, 8'd250, 8'd0, 8'h00, 2'd1,
                 8'h37, 8'hE4, 0, 1'b0, 1'b0, 1'b0);
        run_tile("pal_q3", 9'd16, 9'd16, 8'd0, 8'd0, 8'h10, 2'd2,
                 8'hC1, 8'hE4, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_vwrap();
        run_tile("vwrap", 9'd239, 9'd0, 8'd0, 8'd239, 8'h02, 2'd0,
                 8'h05, 8'h9C, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wait();
        run_tile("wait3", 9'd100, 9'd200, 8'd7, 8'd3, 8'h01, 2'd3,
                 8'hA7, 8'h6D, 3, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_tile("b2b_a", 9'd50, 9'd60, 8'd11, 8'd22, 8'h12, 2'd0,
                 8'h3E, 8'h5B, 1, 1'b0, 1'b0, 1'b1);
        run_tile("b2b_b", 9'd51, 9'd61, 8'd11, 8'd22, 8'h03, 2'd1,
                 8'h81, 8'h2F, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit found;
        inv_cache();
        ack_delay = 3;
        nt_val    = 8'h4C;
        at_val    = 8'h93;
        @(negedge clk);
        pix_row  = 9'd120;
        pix_col  = 9'd130;
        scroll_x = 8'd0;
        scroll_y = 8'd0;
        ctrl     = 8'h00;
        mirror   = 2'd1;
        acked_q.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (acked_q.size() == 1 && mem_req && !mem_ack)
                found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid wait: AT wait state not reached");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, busy, tile_valid, mem_addr, tile_pt_lo, tile_fine_x}
                !== '0) begin
            errors++;
            $display("FAIL reset_mid async: got req=%b busy=%b v=%b a=%h lo=%h fx=%0d required all 0",
                     mem_req, busy, tile_valid, mem_addr, tile_pt_lo,
                     tile_fine_x);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tile_valid || mem_req || busy)
                found = 1'b1;
        end
        checks++;
        if (found) begin
            errors++;
            $display("FAIL reset_mid idle: got activity after reset required none");
        end
        run_tile("post_reset", 9'd120, 9'd130, 8'd0, 8'd0, 8'h00, 2'd1,
                 8'h4C, 8'h93, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_cache();
        run_tile("cache_fill", 9'd77, 9'd88, 8'd5, 8'd9, 8'h10, 2'd1,
                 8'h6A, 8'h3C, 0, 1'b0, 1'b0, 1'b0);
        run_tile("cache_hit", 9'd77, 9'd88, 8'd5, 8'd9, 8'h10, 2'd1,
                 8'h6A, 8'h3C, 0, 1'b0, 1'b1, 1'b0);
        run_tile("cache_inv", 9'd77, 9'd88, 8'd5, 8'd9, 8'h10, 2'd1,
                 8'h6A, 8'h3C, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_tile("random",
                     9'($urandom_range(0, 239)), 9'($urandom_range(0, 255)),
                     8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                     8'($urandom), 8'($urandom), $urandom_range(0, 2),
                     1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scroll();
        test_vwrap();
        test_wait();
        test_back_to_back();
        test_reset_mid();
        test_cache();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppu_tile_fetcher.md
PPU_TILE_FETCHER -- requirements
Module: ppu_tile_fetcher

Interface
REQ-001 Parameter ADDR_W, 16, PPU bus address width (min 14).
REQ-002 Parameter NT_BASE, 16'h2000, nametable region base address.
REQ-003 Parameter PT_STRIDE, 16, bytes per pattern-table tile.
REQ-004 clk  in  1  single clock; all flops on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request one tile fetch; ignored while busy.
REQ-007 pix_row, pix_col  in  9 each  screen pixel position; pix_row<240 and pix_col<256 guaranteed.
REQ-008 scroll_x, scroll_y  in  8 each  fine scroll registers.
REQ-009 ctrl  in  8  PPU control: [0] h-base NT, [1] v-base NT, [4] BG pattern table select.
REQ-010 mirror  in  2  0 horizontal, 1 vertical, 2 single-low, 3 single-high.
REQ-011 cache_inv  in  1  invalidate tile cache.
REQ-012 busy  out  1  high from the cycle after start acceptance until tile_valid.
REQ-013 mem_req / mem_addr  out  1 / ADDR_W  read request and address; mem_ack in 1; mem_rdata in 8.
REQ-014 tile_valid  out  1  one-cycle pulse; tile_pt_lo, tile_pt_hi out 8 each; tile_pal out 2; tile_fine_x out 3.

Function
REQ-015 start, pix_row, pix_col, scroll, ctrl and mirror are sampled only on the edge that accepts start; later changes do not affect the fetch in progress.
REQ-016 row = (pix_row + scroll_y + (ctrl[1] ? 240 : 0)) mod 480, implemented as one conditional subtraction of 480 (sum <= 734).
REQ-017 col = (pix_col + scroll_x + (ctrl[0] ? 256 : 0)) mod 512.
REQ-018 Logical NT v = (row >= 240), h = col[8]; nt_row = v ? row-240 : row; coarse_y = nt_row[7:3], fine_y = nt_row[2:0], coarse_x = col[7:3], tile_fine_x = col[2:0].
REQ-019 Physical NT p: horizontal -> v, vertical -> h, single-low -> 0, single-high -> 1; nt_base = NT_BASE + p*0x400.
REQ-020 Addresses: NT = nt_base + coarse_y*32 + coarse_x; AT = nt_base + 0x3C0 + (coarse_y>>2)*8 + (coarse_x>>2); PT_LO = ctrl[4]*0x1000 + nt_byte*PT_STRIDE + fine_y; PT_HI = PT_LO + 8.
REQ-021 tile_pal = (at_byte >> ({coarse_y[1],1'b0}*2 + {coarse_x[1],1'b0}))[1:0], i.e. shift 0/2/4/6.
REQ-022 FSM: IDLE -> NT -> AT -> PT_LO -> PT_HI -> DONE -> IDLE; each fetch state advances only on a cycle with mem_ack=1.
REQ-023 mem_req is high in every fetch state; mem_addr is stable while mem_req=1 and mem_ack=0; mem_rdata is captured in the mem_ack cycle.
REQ-024 mem_ack may assert in the first req cycle; with zero wait, tile_valid is asserted 5 cycles after the start edge.
REQ-025 DONE: tile_valid=1 for exactly one cycle, outputs are valid and held until the next tile_valid, and mem_req=0.
REQ-026 A start in DONE is ignored; a start in IDLE is accepted.

Reset
REQ-027 rst_n low: FSM to IDLE; mem_req, busy and tile_valid are 0; tile data, mem_addr and tile_fine_x are 0; cache is invalid.
REQ-028 Reset mid-fetch aborts immediately; mem_req drops asynchronously and no tile_valid is produced.

Configuration
REQ-029 With macro PPU_TILE_CACHE_EN, a one-entry cache stores {NT addr, fine_y, ctrl[4]} plus outputs; a start hit goes IDLE -> DONE, giving tile_valid 1 cycle after start with no mem_req.
REQ-030 A cache miss refills the cache on DONE; cache_inv (any state) clears the valid bit, and has priority over a same-cycle refill.
REQ-031 Without PPU_TILE_CACHE_EN, no cache logic exists, cache_inv is ignored, and every start performs 4 fetches.

Structure
REQ-032 Package ppu_pkg holds the FSM state enum, mirror-mode constants, AT offset 0x3C0, the 480/240 row constants and the pattern half size 0x1000.
REQ-033 Combinational coordinate/mirroring mapping (REQ-016..020) lives in sub-module ppu_scroll_map; the FSM, handshake and cache live in ppu_tile_fetcher.

Verification
REQ-034 Row/col 0, scroll 0, ctrl 0, vertical, NT byte 0x24, zero wait -> addresses 0x2000, 0x23C0, 0x0240, 0x0248; tile_valid 5 cycles after start.
REQ-035 pix_row=10, pix_col=20, scroll_x=250, vertical -> NT 0x2421, AT 0x27C0, fine_y 2, tile_fine_x 6, tile_pal = at[1:0].
REQ-036 pix_row=239, scroll_y=239, ctrl[1]=1, horizontal, col 0 -> row 238, NT 0x23A0, PT fine_y 6.
REQ-037 mem_ack delayed 3 cycles per fetch, inputs toggled after start -> mem_addr held stable, results match the sampled inputs, tile_valid 17 cycles after start.
REQ-038 rst_n low during AT wait -> mem_req 0 that cycle, no tile_valid, IDLE; next start fetches normally.
REQ-039 PPU_TILE_CACHE_EN: repeat identical start -> tile_valid after 1 cycle, no mem_req; after cache_inv, the same start performs a full 4-fetch sequence.
